// File: rtl/ascon_params.sv
// ---------------------------------------------------------------------------
// ascon_params
// Shared constants for the masked Ascon randomness source.
//   MASK_ORDER / COL_SIZE / PAR : masking order and datapath shape. These set
//                                 how many fresh mask bits one round step uses.
//   RAND_WIDTH                  : mask bits per round step,
//                                 d*COL_SIZE*PAR + (d+1)*d/2.
//   LFSR_WIDTH / LFSR_POLY      : one lane is a 31-bit Fibonacci LFSR with
//                                 polynomial x^31 + x^28 + 1.
//   LFSR_TAPS                   : feedback tap mask derived from the polynomial.
//   NUM_LFSR                    : number of lanes needed to cover RAND_WIDTH.
//   rand_state_e                : controller states of the randomness source.
// ---------------------------------------------------------------------------
package ascon_params;

    localparam int MASK_ORDER = 2;
    localparam int COL_SIZE   = 5;
    localparam int PAR        = 22;

    localparam int RAND_WIDTH = MASK_ORDER * COL_SIZE * PAR
                              + ((MASK_ORDER + 1) * MASK_ORDER) / 2;

    localparam int LFSR_WIDTH = 31;

    // Bit n of the polynomial word is the coefficient of x^n.
    localparam logic [31:0] LFSR_POLY = 32'h9000_0001;

    // Term x^n taps state bit n-1. The constant x^0 term is implicit in the
    // shift, so the mask is the polynomial without its lowest bit. This gives
    // 31'h48000000, which selects bits 30 and 27.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_POLY[LFSR_WIDTH:1];

    localparam int NUM_LFSR = (RAND_WIDTH + LFSR_WIDTH - 1) / LFSR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } rand_state_e;

endpackage

// File: rtl/ascon_lfsr_lane.sv
// ---------------------------------------------------------------------------
// ascon_lfsr_lane
// One Fibonacci LFSR lane of the randomness source.
// A single step is s' = {s[W-2:0], ^(s & TAPS)}.
// A block-advance applies W single steps in one cycle. After a block-advance,
// every bit of the lane comes from fresh feedback.
// A zero seed would lock the LFSR at zero. The lane therefore loads
// LANE_INDEX+1 in place of a zero seed.
//   clk_i, rst_i : clock, asynchronous active-high reset (lane cleared to 0)
//   load         : capture seed (with zero substitution)
//   seed         : seed value
//   advance      : perform one block-advance
//   lane         : current lane contents
// ---------------------------------------------------------------------------
module ascon_lfsr_lane
    import ascon_params::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS),
    parameter int               LANE_INDEX = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic [WIDTH-1:0] lane
);

    localparam logic [WIDTH-1:0] ZERO_SUBST = WIDTH'(LANE_INDEX + 1);

    logic [WIDTH-1:0] lane_q;
    logic [WIDTH-1:0] lane_adv;
    logic [WIDTH-1:0] seed_fixed;

    // WIDTH single steps, fully unrolled into one combinational block.
    function automatic logic [WIDTH-1:0] block_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < WIDTH; i++) begin
            v = {v[WIDTH-2:0], ^(v & TAPS)};
        end
        return v;
    endfunction

    // Compute the next-block value and the zero-safe seed for this lane.
    always_comb begin
        lane_adv   = block_advance(lane_q);
        seed_fixed = (seed == '0) ? ZERO_SUBST : seed;
    end

    // Lane register. Load and advance are never requested in the same cycle.
    // If both were asserted, load would take priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q <= '0;
        end else if (load) begin
            lane_q <= seed_fixed;
        end else if (advance) begin
            lane_q <= lane_adv;
        end
    end

    assign lane = lane_q;

endmodule

// File: rtl/ascon_rand_gen.sv
// ---------------------------------------------------------------------------
// ascon_rand_gen
// Fresh-randomness source for the masked Ascon permutation core.
// The source holds NUM_LFSR lanes of LFSR_WIDTH-bit LFSRs. It loads them one
// seed beat at a time, runs WARMUP_BLOCKS block-advances, and then presents
// RAND_WIDTH bits per cycle on a valid/ready interface. Each accepted word is
// replaced by an entirely new word on the following cycle.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   seed_i, seed_valid_i      : seed beat for lane k
//   seed_ready_o              : seed beats accepted (SEED state)
//   reseed_i                  : pulse that restarts seeding from lane 0
//   rnd_o, rnd_valid_o        : mask randomness and its valid flag
//   rnd_ready_i               : consumer takes rnd_o
// ---------------------------------------------------------------------------
module ascon_rand_gen
    import ascon_params::*;
#(
    parameter int RAND_WIDTH    = ascon_params::RAND_WIDTH,
    parameter int LFSR_WIDTH    = ascon_params::LFSR_WIDTH,
    parameter int NUM_LFSR      = (RAND_WIDTH + LFSR_WIDTH - 1) / LFSR_WIDTH,
    parameter int WARMUP_BLOCKS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [LFSR_WIDTH-1:0] seed_i,
    input  logic                  seed_valid_i,
    output logic                  seed_ready_o,
    input  logic                  reseed_i,
    output logic [RAND_WIDTH-1:0] rnd_o,
    output logic                  rnd_valid_o,
    input  logic                  rnd_ready_i
);

    localparam int KW = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
    localparam int WW = (WARMUP_BLOCKS > 1) ? $clog2(WARMUP_BLOCKS) : 1;

    localparam logic [KW-1:0] K_LAST    = KW'(NUM_LFSR - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_BLOCKS - 1);
    localparam int            FLAT_W    = NUM_LFSR * LFSR_WIDTH;

    rand_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [WW-1:0] warm_q, warm_d;

    logic                seed_accept;
    logic                advance_all;
    logic [NUM_LFSR-1:0] lane_load;
    logic [FLAT_W-1:0]   lanes_flat;

    // Controller state, seed beat counter and warm-up counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            warm_q  <= warm_d;
        end
    end

    // Next-state logic and the strobes decoded from the registered state.
    // A reseed pulse outside IDLE overrides the normal transition.
    // In SEED, the pulse also discards the beat that arrives with it.
    // In RUN, a handshake in the same cycle still advances the lanes,
    // so that word counts as consumed.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        warm_d       = warm_q;
        seed_ready_o = 1'b0;
        rnd_valid_o  = 1'b0;
        seed_accept  = 1'b0;
        advance_all  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = SEED;
                k_d     = '0;
            end
            SEED: begin
                seed_ready_o = 1'b1;
                if (seed_valid_i) begin
                    seed_accept = !reseed_i;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        warm_d  = '0;
                        state_d = (WARMUP_BLOCKS == 0) ? RUN : WARMUP;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            WARMUP: begin
                advance_all = 1'b1;
                if (warm_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            RUN: begin
                rnd_valid_o = 1'b1;
                advance_all = rnd_ready_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reseed_i && (state_q != IDLE)) begin
            state_d = SEED;
            k_d     = '0;
        end
    end

    // Lane bank. Lane i sits at bits [i*LFSR_WIDTH +: LFSR_WIDTH] of the word,
    // so lane 0 drives the least significant bits.
    for (genvar i = 0; i < NUM_LFSR; i++) begin : gen_lane
        assign lane_load[i] = seed_accept && (k_q == KW'(i));

        ascon_lfsr_lane #(
            .WIDTH      (LFSR_WIDTH),
            .TAPS       (LFSR_WIDTH'(LFSR_TAPS)),
            .LANE_INDEX (i)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load    (lane_load[i]),
            .seed    (seed_i),
            .advance (advance_all),
            .lane    (lanes_flat[i*LFSR_WIDTH +: LFSR_WIDTH])
        );
    end

    assign rnd_o = lanes_flat[RAND_WIDTH-1:0];

    // The top lane is only partly exposed. Its upper bits keep running
    // but never reach the output.
    if (FLAT_W > RAND_WIDTH) begin : gen_trunc
        logic lanes_unused;
        assign lanes_unused = ^lanes_flat[FLAT_W-1:RAND_WIDTH];
    end

endmodule

// File: tb/tb_ascon_rand_gen.sv
// ---------------------------------------------------------------------------
// tb_ascon_rand_gen
// Directed self-checking bench for ascon_rand_gen.
// dut0 runs without warm-up and dut4 runs with the default four warm-up
// blocks. Both instances share the clock and reset.
// ---------------------------------------------------------------------------
module tb_ascon_rand_gen;
    import ascon_params::*;

    localparam int RW = RAND_WIDTH;
    localparam int LW = LFSR_WIDTH;
    localparam int NL = NUM_LFSR;

    logic clk = 1'b0;
    logic rst;

    logic [LW-1:0] seed0, seed4;
    logic          seed_valid0, seed_valid4;
    logic          sready0, sready4;
    logic          reseed0, reseed4;
    logic [RW-1:0] rnd0, rnd4;
    logic          valid0, valid4;
    logic          ready0, ready4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] model [NL];
    logic [LW-1:0] seeds [NL];
    logic [RW-1:0] exp_word;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    ascon_rand_gen #(.WARMUP_BLOCKS(0)) dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .seed_i       (seed0),
        .seed_valid_i (seed_valid0),
        .seed_ready_o (sready0),
        .reseed_i     (reseed0),
        .rnd_o        (rnd0),
        .rnd_valid_o  (valid0),
        .rnd_ready_i  (ready0)
    );

    ascon_rand_gen dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .seed_i       (seed4),
        .seed_valid_i (seed_valid4),
        .seed_ready_o (sready4),
        .reseed_i     (reseed4),
        .rnd_o        (rnd4),
        .rnd_valid_o  (valid4),
        .rnd_ready_i  (ready4)
    );

    // Reference block-advance: 31 steps of s' = {s[29:0], s[30]^s[27]}.
    function automatic logic [LW-1:0] ref_advance(input logic [LW-1:0] s);
        logic [LW-1:0] v;
        v = s;
        for (int i = 0; i < 31; i++) begin
            v = {v[29:0], v[30] ^ v[27]};
        end
        return v;
    endfunction

    function automatic logic [RW-1:0] pack_model();
        logic [NL*LW-1:0] f;
        for (int i = 0; i < NL; i++) begin
            f[i*LW +: LW] = model[i];
        end
        return f[RW-1:0];
    endfunction

    task automatic model_advance();
        for (int i = 0; i < NL; i++) begin
            model[i] = ref_advance(model[i]);
        end
    endtask

    // Sends all eight seeds to dut0 back to back.
    // Before the last beat, the output must still be invalid.
    task automatic seed_dut0();
        for (int i = 0; i < NL; i++) begin
            seed0       = seeds[i];
            seed_valid0 = 1'b1;
            model[i]    = (seeds[i] == '0) ? LW'(i + 1) : seeds[i];
            @(posedge clk); #1;
            seed_valid0 = 1'b0;
            if (i < NL - 1) begin
                n_checks++;
                if (valid0 !== 1'b0 || sready0 !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL seed0_beat%0d: valid=%b ready=%b expected valid=0 ready=1", i, valid0, sready0);
                end
            end
        end
    endtask

    // Sends all eight seeds to dut4, with one idle cycle before beat gap_at.
    task automatic seed_dut4(input int gap_at);
        for (int i = 0; i < NL; i++) begin
            if (i == gap_at) begin
                seed_valid4 = 1'b0;
                seed4       = 31'h7ABC_DEF0;
                @(posedge clk); #1;
                n_checks++;
                if (sready4 !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL seed4_gap: seed_ready=%b expected 1", sready4);
                end
            end
            seed4       = seeds[i];
            seed_valid4 = 1'b1;
            model[i]    = seeds[i];
            @(posedge clk); #1;
            seed_valid4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rnd0 !== '0 || valid0 !== 1'b0 || sready0 !== 1'b0 ||
            rnd4 !== '0 || valid4 !== 1'b0 || sready4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: v0=%b r0=%b v4=%b r4=%b rnd0=%h expected all 0",
                     valid0, sready0, valid4, sready4, rnd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (sready0 !== 1'b0 || sready4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: seed_ready0=%b seed_ready4=%b expected 0", sready0, sready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sready0 !== 1'b1 || sready4 !== 1'b1 || valid0 !== 1'b0 || valid4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: seed_ready0=%b seed_ready4=%b valid0=%b valid4=%b expected 1 1 0 0",
                     sready0, sready4, valid0, valid4);
        end
    endtask

    task automatic test_seed_no_warmup();
        for (int i = 0; i < NL; i++) seeds[i] = LW'(i + 1);
        seed_dut0();
        exp_word = {6'h08, 31'd7, 31'd6, 31'd5, 31'd4, 31'd3, 31'd2, 31'd1};
        n_checks++;
        if (valid0 !== 1'b1 || sready0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL seed_nowarm_valid: valid=%b seed_ready=%b expected 1 0", valid0, sready0);
        end
        n_checks++;
        if (rnd0 !== exp_word) begin
            n_fail++;
            $display("[TB] FAIL seed_nowarm_word: got %h expected %h", rnd0, exp_word);
        end
        ready0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rnd0 !== exp_word || valid0 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL seed_nowarm_hold%0d: got %h valid=%b expected %h valid=1", c, rnd0, valid0, exp_word);
            end
        end
    endtask

    task automatic test_block_advance();
        ready0 = 1'b1;
        @(posedge clk); #1;
        ready0 = 1'b0;
        model_advance();
        n_checks++;
        if (rnd0[30:0] !== 31'h0000_0009) begin
            n_fail++;
            $display("[TB] FAIL blk_adv_lane0: got %h expected 00000009", rnd0[30:0]);
        end
        n_checks++;
        if (rnd0[61:31] !== 31'h0000_0012) begin
            n_fail++;
            $display("[TB] FAIL blk_adv_lane1: got %h expected 00000012", rnd0[61:31]);
        end
        n_checks++;
        if (rnd0 !== pack_model()) begin
            n_fail++;
            $display("[TB] FAIL blk_adv_word: got %h expected %h", rnd0, pack_model());
        end
        @(posedge clk); #1;
        n_checks++;
        if (rnd0 !== pack_model() || valid0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL blk_adv_hold: got %h expected %h", rnd0, pack_model());
        end
    endtask

    task automatic test_zero_seed();
        reseed0 = 1'b1;
        @(posedge clk); #1;
        reseed0 = 1'b0;
        n_checks++;
        if (valid0 !== 1'b0 || sready0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_reseed: valid=%b seed_ready=%b expected 0 1", valid0, sready0);
        end
        seeds[0] = 31'h0000_0101; seeds[1] = 31'h0000_0202;
        seeds[2] = 31'h0000_0303; seeds[3] = 31'h0000_0000;
        seeds[4] = 31'h0000_0505; seeds[5] = 31'h0000_0606;
        seeds[6] = 31'h0000_0707; seeds[7] = 31'h0000_0808;
        seed_dut0();
        n_checks++;
        if (rnd0[123:93] !== 31'd4) begin
            n_fail++;
            $display("[TB] FAIL zero_seed_lane3: got %h expected 00000004", rnd0[123:93]);
        end
        n_checks++;
        if (rnd0 !== pack_model() || valid0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_seed_word: got %h valid=%b expected %h valid=1", rnd0, valid0, pack_model());
        end
    endtask

    task automatic test_warmup_backpressure();
        seeds[0] = 31'h0123_4567; seeds[1] = 31'h7FFF_FFFF;
        seeds[2] = 31'h0000_0001; seeds[3] = 31'h4000_0000;
        seeds[4] = 31'h2AAA_AAAA; seeds[5] = 31'h5555_5555;
        seeds[6] = 31'h0F0F_0F0F; seeds[7] = 31'h7000_0001;
        ready4 = 1'b0;
        seed_dut4(3);
        n_checks++;
        if (valid4 !== 1'b0 || sready4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL warm_enter: valid=%b seed_ready=%b expected 0 0", valid4, sready4);
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid4 !== (c == 4)) begin
                n_fail++;
                $display("[TB] FAIL warm_cycle%0d: valid=%b expected %b", c, valid4, (c == 4));
            end
        end
        for (int i = 0; i < 4; i++) model_advance();
        n_checks++;
        if (rnd4 !== pack_model()) begin
            n_fail++;
            $display("[TB] FAIL warm_word: got %h expected %h", rnd4, pack_model());
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rnd4 !== pack_model() || valid4 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL backpressure%0d: got %h valid=%b expected %h", c, rnd4, valid4, pack_model());
            end
        end
        ready4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            model_advance();
            n_checks++;
            if (rnd4 !== pack_model() || valid4 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL back_to_back%0d: got %h valid=%b expected %h", c, rnd4, valid4, pack_model());
            end
        end
    endtask

    task automatic test_reseed_collision();
        // ready4 is still high, so this cycle is a handshake and a reseed.
        reseed4 = 1'b1;
        @(posedge clk); #1;
        reseed4 = 1'b0;
        ready4  = 1'b0;
        model_advance();
        n_checks++;
        if (valid4 !== 1'b0 || sready4 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collide_state: valid=%b seed_ready=%b expected 0 1", valid4, sready4);
        end
        n_checks++;
        if (rnd4 !== pack_model()) begin
            n_fail++;
            $display("[TB] FAIL collide_consumed: got %h expected %h", rnd4, pack_model());
        end
        // Two beats, then a beat that coincides with reseed and must be dropped.
        seed4 = 31'h0000_AAAA; seed_valid4 = 1'b1; model[0] = 31'h0000_AAAA;
        @(posedge clk); #1;
        seed4 = 31'h0000_BBBB; model[1] = 31'h0000_BBBB;
        @(posedge clk); #1;
        seed4 = 31'h0003_DEAD; reseed4 = 1'b1;
        @(posedge clk); #1;
        seed_valid4 = 1'b0;
        reseed4     = 1'b0;
        n_checks++;
        if (rnd4 !== pack_model() || sready4 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collide_discard: got %h seed_ready=%b expected %h", rnd4, sready4, pack_model());
        end
        seeds[0] = 31'h1111_1111; seeds[1] = 31'h2222_2222;
        seeds[2] = 31'h3333_3333; seeds[3] = 31'h4444_4444;
        seeds[4] = 31'h5555_0000; seeds[5] = 31'h6666_6666;
        seeds[6] = 31'h7777_7777; seeds[7] = 31'h0000_0123;
        seed_dut4(-1);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) model_advance();
        n_checks++;
        if (rnd4 !== pack_model() || valid4 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collide_reseeded: got %h valid=%b expected %h", rnd4, valid4, pack_model());
        end
    endtask

    task automatic test_mid_reset();
        ready4 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rnd4 !== '0 || valid4 !== 1'b0 || sready4 !== 1'b0 || rnd0 !== '0 || valid0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: rnd4=%h valid4=%b seed_ready4=%b rnd0=%h expected 0",
                     rnd4, valid4, sready4, rnd0);
        end
        ready4 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rnd4 !== '0 || valid4 !== 1'b0 || sready4 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_hold: rnd4=%h valid4=%b seed_ready4=%b expected 0", rnd4, valid4, sready4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        seed0       = '0; seed4       = '0;
        seed_valid0 = 1'b0; seed_valid4 = 1'b0;
        reseed0     = 1'b0; reseed4     = 1'b0;
        ready0      = 1'b0; ready4      = 1'b0;
        for (int i = 0; i < NL; i++) begin
            model[i] = '0;
            seeds[i] = '0;
        end
        exp_word = '0;

        $display("[TB] starting ascon_rand_gen directed tests");
        test_reset();
        test_seed_no_warmup();
        test_block_advance();
        test_zero_seed();
        test_warmup_backpressure();
        test_reseed_collision();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
